// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 encodings,
// FSM state type and operation classification.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, dvd} left, trial-subtract the
// divisor, and shift the resulting quotient bit into the dividend LSB.
module div_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] dvd_next
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;
  logic            borrow;

  // One guard bit above the remainder so the borrow of the trial subtract is exact.
  always_comb begin
    shifted  = {rem, dvd[XLEN-1]};
    diff     = shifted - {2'b00, divisor};
    borrow   = diff[XLEN+1];
    rem_next = borrow ? shifted[XLEN:0] : diff[XLEN:0];
    dvd_next = {dvd[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: single-cycle multiply, 32-step restoring divide with
// one-cycle handling of divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [XLEN:0]     rem;
  logic [XLEN:0]     rem_next;
  logic [XLEN-1:0]   dvd;
  logic [XLEN-1:0]   dvd_next;
  logic [XLEN-1:0]   divisor;
  logic              q_neg;
  logic              r_neg;
  logic              rem_sel;
  logic              accept;

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  logic                     a_sx;
  logic                     b_sx;
  logic signed [2*XLEN+1:0] ext_a;
  logic signed [2*XLEN+1:0] ext_b;
  logic signed [2*XLEN+1:0] product;
  logic [XLEN-1:0]          mul_res;
  logic                     unused_prod;

  // Extended operands make one signed multiplier cover all four multiply flavours.
  always_comb begin
    a_sx    = (funct3 != F3_MULHU) && op_a[XLEN-1];
    b_sx    = (funct3 == F3_MULH) && op_b[XLEN-1];
    ext_a   = signed'({{(XLEN+2){a_sx}}, op_a});
    ext_b   = signed'({{(XLEN+2){b_sx}}, op_b});
    product = ext_a * ext_b;
    mul_res = (funct3[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  assign unused_prod = ^product[2*XLEN+1:2*XLEN];

  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  always_comb begin
    div_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg      = div_signed && op_a[XLEN-1];
    b_neg      = div_signed && op_b[XLEN-1];
    a_mag      = neg_if(a_neg, op_a);
    b_mag      = neg_if(b_neg, op_b);
    div_zero   = (op_b == '0);
    div_ovf    = div_signed && (op_a == INT_MIN) && (op_b == '1);
  end

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (divisor),
    .rem_next (rem_next),
    .dvd_next (dvd_next)
  );

  // Divider datapath: loaded on accept, advanced one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= '0;
      dvd     <= a_mag;
      divisor <= b_mag;
      q_neg   <= a_neg ^ b_neg;
      r_neg   <= a_neg;
      rem_sel <= funct3[1];
    end else if (state == RUN) begin
      rem <= rem_next;
      dvd <= dvd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count <= '0;
            if (!is_div(funct3)) begin
              result <= mul_res;
              state  <= DONE;
            end else if (div_zero) begin
              result <= funct3[1] ? op_a : '1;
              state  <= DONE;
            end else if (div_ovf) begin
              result <= funct3[1] ? '0 : INT_MIN;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == LAST) begin
            result <= rem_sel ? neg_if(r_neg, rem_next[XLEN-1:0]) : neg_if(q_neg, dvd_next);
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, ub;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles busy stays high: one for multiply and special cases, else XLEN steps plus DONE.
  function automatic int exp_cycles(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 1;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int bcyc, output int ndone);
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    bcyc = 0; ndone = 0; res = 32'hDEAD_BEEF;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) begin ndone++; res = result; end
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  f3s [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] res, a, b, exp;
    logic [2:0]  f3;
    int          bc, nd;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin f3 = f3s[i]; a = 32'd7; b = 32'hFFFF_FFFD; end
      else begin f3 = 3'($urandom_range(0, 3)); a = $urandom; b = $urandom; end
      exp = ref_op(f3, a, b);
      do_op(f3, a, b, res, bc, nd);
      checks++; if (res !== exp) begin errors++; $display("FAIL mul_result f3=%0d a=%h b=%h got %h want %h", f3, a, b, res, exp); end
      checks++; if (bc !== 1) begin errors++; $display("FAIL mul_busy_cycles f3=%0d got %0d want 1", f3, bc); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL mul_done_count f3=%0d got %0d want 1", f3, nd); end
    end
    repeat (2) @(negedge clk);
    checks++; if (result !== exp) begin errors++; $display("FAIL result_hold got %h want %h", result, exp); end
  endtask

  task automatic test_div();
    logic [2:0]  f3s [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] as [4]  = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100};
    logic [31:0] bs [4]  = '{32'd3, 32'd3, 32'd7, 32'd7};
    logic [31:0] res, a, b, exp;
    logic [2:0]  f3;
    int          bc, nd, ec;
    for (int i = 0; i < 16; i++) begin
      if (i < 4) begin f3 = f3s[i]; a = as[i]; b = bs[i]; end
      else begin
        f3 = 3'($urandom_range(4, 7));
        a  = $urandom;
        b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)) * ((i % 4 == 1) ? 32'hFFFF_FFFF : 32'd1);
      end
      exp = ref_op(f3, a, b);
      ec  = exp_cycles(f3, a, b);
      do_op(f3, a, b, res, bc, nd);
      checks++; if (res !== exp) begin errors++; $display("FAIL div_result f3=%0d a=%h b=%h got %h want %h", f3, a, b, res, exp); end
      checks++; if (bc !== ec) begin errors++; $display("FAIL div_busy_cycles f3=%0d got %0d want %0d", f3, bc, ec); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL div_done_count f3=%0d got %0d want 1", f3, nd); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] as [6]  = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd7};
    logic [31:0] bs [6]  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    logic [31:0] want [6] = '{32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] res;
    int          bc, nd;
    for (int i = 0; i < 6; i++) begin
      do_op(f3s[i], as[i], bs[i], res, bc, nd);
      checks++; if (res !== want[i]) begin errors++; $display("FAIL special_result idx=%0d got %h want %h", i, res, want[i]); end
      checks++; if (bc !== 1) begin errors++; $display("FAIL special_busy_cycles idx=%0d got %0d want 1", i, bc); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL special_done_count idx=%0d got %0d want 1", i, nd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int          bc, nd;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk);
    #1;
    op_a = 32'd999;
    bc = 0; nd = 0; res = 32'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin nd++; res = result; end
      if (!busy) break;
    end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL hold_start_result got %h want %h", res, 32'd14); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL hold_start_busy_cycles got %0d want 33", bc); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL hold_start_done_count got %0d want 1", nd); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL hold_start_idle_result got %h want %h", result, 32'd14); end
    @(posedge clk);
    #1;
    start = 1'b0;
    bc = 0; nd = 0; res = 32'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin nd++; res = result; end
      if (!busy) break;
    end
    checks++; if (res !== 32'd142) begin errors++; $display("FAIL second_op_result got %h want %h", res, 32'd142); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL second_op_busy_cycles got %0d want 33", bc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          bc, nd;
    @(negedge clk);
    start = 1'b1; funct3 = 3'd4; op_a = 32'hFFFF_FFEC; op_b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_run_busy got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 0", result); end
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done got %0d active cycles want 0", nd); end
    do_op(3'd0, 32'd3, 32'd4, res, bc, nd);
    checks++; if (res !== 32'd12) begin errors++; $display("FAIL post_reset_mul got %h want %h", res, 32'd12); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL post_reset_done_count got %0d want 1", nd); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
